// File: rtl/vga_pkg.sv
// Shared constants for the VGA test-pattern blocks: coordinate widths,
// default 720p resolution and the box animator FSM state encoding.
package vga_pkg;

  localparam int COORD_W     = 13;
  localparam int FRAME_CNT_W = 16;
  localparam int SPEED_W     = 3;

  // Default active area (1280x720), matching the vga_timing 720p selection.
  localparam int RES_H_720P  = 1280;
  localparam int RES_V_720P  = 720;

  // Box animator sequencer states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STEP_X = 2'd1;
  localparam logic [1:0] ST_STEP_Y = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

endpackage

// File: rtl/box_axis_stepper.sv
// Combinational single-axis stepper: advances a position by spd in the
// current direction and bounces off 0 and limit. One instance is shared
// between the X and Y axes by the animator FSM.
module box_axis_stepper
  import vga_pkg::*;
(
  input  logic [COORD_W-1:0] pos_i,
  input  logic               dir_i,    // 1 = increasing, 0 = decreasing
  input  logic [SPEED_W-1:0] spd_i,
  input  logic [COORD_W-1:0] limit_i,
  output logic [COORD_W-1:0] pos_o,
  output logic               dir_o
);

  // One extra bit so pos+spd can never wrap before the limit compare.
  logic [COORD_W:0] pos_ext;
  logic [COORD_W:0] spd_ext;
  logic [COORD_W:0] lim_ext;
  logic [COORD_W:0] sum;

  // Bounce arithmetic; spd=0 leaves both position and direction untouched,
  // even when the box already sits on an edge.
  always_comb begin
    pos_ext = {1'b0, pos_i};
    spd_ext = {{(COORD_W + 1 - SPEED_W){1'b0}}, spd_i};
    lim_ext = {1'b0, limit_i};
    sum     = pos_ext + spd_ext;
    pos_o   = pos_i;
    dir_o   = dir_i;
    if (spd_i != '0) begin
      if (dir_i) begin
        if (sum >= lim_ext) begin
          pos_o = limit_i;
          dir_o = 1'b0;
        end else begin
          pos_o = sum[COORD_W-1:0];
        end
      end else begin
        if (pos_ext <= spd_ext) begin
          pos_o = '0;
          dir_o = 1'b1;
        end else begin
          pos_o = pos_i - COORD_W'(spd_i);
        end
      end
    end
  end

endmodule

// File: rtl/vga_box_animator.sv
// Frame-synchronous box animator: on each vertical-sync leading edge it
// steps the box position (X then Y through one shared stepper) and
// publishes new inclusive bounds, so the window never changes mid-frame.
module vga_box_animator
  import vga_pkg::*;
#(
  parameter int   RES_H        = RES_H_720P,
  parameter int   RES_V        = RES_V_720P,
  parameter int   BOX_W        = 200,
  parameter int   BOX_H        = 120,
  parameter int   INIT_X       = 50,
  parameter int   INIT_Y       = 100,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input  logic                   pixel_clk_i,
  input  logic                   rst_ni,
  input  logic                   sync_v_i,
  input  logic                   enable_i,
  input  logic [SPEED_W-1:0]     speed_i,
  output logic [COORD_W-1:0]     box_x_lo_o,
  output logic [COORD_W-1:0]     box_x_hi_o,
  output logic [COORD_W-1:0]     box_y_lo_o,
  output logic [COORD_W-1:0]     box_y_hi_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic                   update_o
);

  localparam logic [COORD_W-1:0] LIMIT_X  = COORD_W'(RES_H - BOX_W);
  localparam logic [COORD_W-1:0] LIMIT_Y  = COORD_W'(RES_V - BOX_H);
  localparam logic [COORD_W-1:0] INIT_X_C = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] INIT_Y_C = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] BOX_W_M1 = COORD_W'(BOX_W - 1);
  localparam logic [COORD_W-1:0] BOX_H_M1 = COORD_W'(BOX_H - 1);

  logic                   sync_q, sync_prev_q;
  logic                   frame_edge;
  logic [1:0]             state_q, state_d;
  logic [SPEED_W-1:0]     spd_q, spd_d;
  logic [COORD_W-1:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic                   dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [COORD_W-1:0]     x_lo_q, x_lo_d, x_hi_q, x_hi_d;
  logic [COORD_W-1:0]     y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic                   update_q, update_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic [COORD_W-1:0]     step_pos, step_limit, step_pos_nxt;
  logic                   step_dir, step_dir_nxt;

  // The history resets to the active level so that a sync line already
  // high at reset release is not mistaken for a new frame.
  assign frame_edge = (sync_q == VSYNC_ACTIVE) && (sync_prev_q != VSYNC_ACTIVE);

  // Register vertical sync and keep one cycle of history for edge detect.
  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= VSYNC_ACTIVE;
      sync_prev_q <= VSYNC_ACTIVE;
    end else begin
      sync_q      <= sync_v_i;
      sync_prev_q <= sync_q;
    end
  end

  // Count every frame edge regardless of enable or sequencer state.
  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= '0;
    end else if (frame_edge) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Time-share the stepper: Y operands during STEP_Y, X operands otherwise.
  always_comb begin
    step_pos   = pos_x_q;
    step_dir   = dir_x_q;
    step_limit = LIMIT_X;
    if (state_q == ST_STEP_Y) begin
      step_pos   = pos_y_q;
      step_dir   = dir_y_q;
      step_limit = LIMIT_Y;
    end
  end

  box_axis_stepper u_stepper (
    .pos_i   (step_pos),
    .dir_i   (step_dir),
    .spd_i   (spd_q),
    .limit_i (step_limit),
    .pos_o   (step_pos_nxt),
    .dir_o   (step_dir_nxt)
  );

  // Sequencer next state. The bound registers are loaded on the
  // STEP_Y -> COMMIT transition so that they, together with update,
  // are visible during the COMMIT cycle itself.
  always_comb begin
    state_d  = state_q;
    spd_d    = spd_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    x_lo_d   = x_lo_q;
    x_hi_d   = x_hi_q;
    y_lo_d   = y_lo_q;
    y_hi_d   = y_hi_q;
    update_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Edges arriving in any other state are simply dropped.
        if (frame_edge && enable_i) begin
          spd_d   = speed_i;
          state_d = ST_STEP_X;
        end
      end
      ST_STEP_X: begin
        pos_x_d = step_pos_nxt;
        dir_x_d = step_dir_nxt;
        state_d = ST_STEP_Y;
      end
      ST_STEP_Y: begin
        pos_y_d  = step_pos_nxt;
        dir_y_d  = step_dir_nxt;
        x_lo_d   = pos_x_q;
        x_hi_d   = pos_x_q + BOX_W_M1;
        y_lo_d   = step_pos_nxt;
        y_hi_d   = step_pos_nxt + BOX_H_M1;
        update_d = 1'b1;
        state_d  = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer, position and published-bound registers.
  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      spd_q    <= '0;
      pos_x_q  <= INIT_X_C;
      pos_y_q  <= INIT_Y_C;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      x_lo_q   <= INIT_X_C;
      x_hi_q   <= INIT_X_C + BOX_W_M1;
      y_lo_q   <= INIT_Y_C;
      y_hi_q   <= INIT_Y_C + BOX_H_M1;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      spd_q    <= spd_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      x_lo_q   <= x_lo_d;
      x_hi_q   <= x_hi_d;
      y_lo_q   <= y_lo_d;
      y_hi_q   <= y_hi_d;
      update_q <= update_d;
    end
  end

  assign box_x_lo_o    = x_lo_q;
  assign box_x_hi_o    = x_hi_q;
  assign box_y_lo_o    = y_lo_q;
  assign box_y_hi_o    = y_hi_q;
  assign frame_count_o = frame_cnt_q;
  assign update_o      = update_q;

endmodule

// File: tb/tb_vga_box_animator.sv
// Directed bench for vga_box_animator with default parameters.
// Expected values are hand-computed box positions.
module tb_vga_box_animator;

  logic        clk;
  logic        rst_n;
  logic        sync_v;
  logic        enable;
  logic [2:0]  speed;
  logic [12:0] x_lo, x_hi, y_lo, y_hi;
  logic [15:0] fcnt;
  logic        upd;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses, first_at, acc;

  vga_box_animator dut (
    .pixel_clk_i   (clk),
    .rst_ni        (rst_n),
    .sync_v_i      (sync_v),
    .enable_i      (enable),
    .speed_i       (speed),
    .box_x_lo_o    (x_lo),
    .box_x_hi_o    (x_hi),
    .box_y_lo_o    (y_lo),
    .box_y_hi_o    (y_hi),
    .frame_count_o (fcnt),
    .update_o      (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Checks all four bounds given the expected top-left corner.
  task automatic check_box(input string tag, input int xl, input int yl);
    check_val({tag, ".x_lo"}, int'(x_lo), xl);
    check_val({tag, ".x_hi"}, int'(x_hi), xl + 199);
    check_val({tag, ".y_lo"}, int'(y_lo), yl);
    check_val({tag, ".y_hi"}, int'(y_hi), yl + 119);
  endtask

  // One frame: sync low for 2 cycles, then high; observe 6 cycles and
  // report the number of update pulses and the cycle of the first one
  // (cycle 1 = first sample after the rising sync is clocked in).
  task automatic run_frame(input logic [2:0] spd, output int np, output int at);
    @(negedge clk); sync_v = 1'b0;
    @(negedge clk);
    @(negedge clk); speed = spd; sync_v = 1'b1;
    np = 0; at = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      if (upd) begin
        np++;
        if (at == 0) at = i;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sync_v = 1'b1; enable = 1'b0; speed = 3'd0;

    // 1. reset values, and no spurious update after release with sync high
    repeat (3) @(negedge clk);
    #1;
    check_box("rst", 50, 100);
    check_val("rst.fcnt", int'(fcnt), 0);
    check_val("rst.upd", int'(upd), 0);
    @(negedge clk); rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (upd) acc++;
    end
    check_val("rel.no_upd", acc, 0);
    check_val("rel.fcnt", int'(fcnt), 0);

    // 2. single step at speed 4, latency 3 cycles after edge detect
    enable = 1'b1;
    run_frame(3'd4, pulses, first_at);
    check_val("step.pulses", pulses, 1);
    check_val("step.latency", first_at, 4);
    check_box("step", 54, 104);
    check_val("step.fcnt", int'(fcnt), 1);

    // 3. walk to x=1078 (y bounces off bottom on the way), then bounce right
    for (int i = 0; i < 146; i++) run_frame(3'd7, pulses, first_at);
    run_frame(3'd2, pulses, first_at);
    check_box("pre_right", 1078, 73);
    run_frame(3'd4, pulses, first_at);
    check_box("right", 1080, 69);
    run_frame(3'd4, pulses, first_at);
    check_box("right_next", 1076, 65);

    // 4. top bounce
    for (int i = 0; i < 9; i++) run_frame(3'd7, pulses, first_at);
    check_box("pre_top", 1013, 2);
    run_frame(3'd4, pulses, first_at);
    check_box("top", 1009, 0);
    run_frame(3'd4, pulses, first_at);
    check_box("top_next", 1005, 4);
    check_val("walk.fcnt", int'(fcnt), 161);

    // 5. enable=0 holds position but frames are still counted
    enable = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      run_frame(3'd5, pulses, first_at);
      acc += pulses;
    end
    check_val("hold.pulses", acc, 0);
    check_val("hold.fcnt", int'(fcnt), 164);
    check_box("hold", 1005, 4);
    enable = 1'b1;
    run_frame(3'd0, pulses, first_at);
    check_val("spd0.pulses", pulses, 1);
    check_box("spd0", 1005, 4);
    check_val("spd0.fcnt", int'(fcnt), 165);

    // 6. reset asserted during STEP_Y
    @(negedge clk); sync_v = 1'b0;
    @(negedge clk);
    @(negedge clk); speed = 3'd4; sync_v = 1'b1;
    @(negedge clk);            // edge-detect cycle
    @(negedge clk);            // STEP_X
    @(negedge clk);            // STEP_Y
    rst_n = 1'b0;
    #1;
    check_box("midrst", 50, 100);
    check_val("midrst.upd", int'(upd), 0);
    check_val("midrst.fcnt", int'(fcnt), 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (upd) acc++;
    end
    check_val("midrst.no_upd", acc, 0);
    run_frame(3'd4, pulses, first_at);
    check_val("postrst.pulses", pulses, 1);
    check_box("postrst", 54, 104);
    check_val("postrst.fcnt", int'(fcnt), 1);

    // 7. second edge while the sequence is busy is dropped but counted
    @(negedge clk); sync_v = 1'b0;
    @(negedge clk);
    @(negedge clk); sync_v = 1'b1;
    acc = 0;
    @(negedge clk); #1; if (upd) acc++;
    @(negedge clk); #1; if (upd) acc++;
    sync_v = 1'b0;
    @(negedge clk); #1; if (upd) acc++;
    sync_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (upd) acc++;
    end
    check_val("drop.pulses", acc, 1);
    check_box("drop", 58, 108);
    check_val("drop.fcnt", int'(fcnt), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
